// File: rtl/wb_tgt_chk.sv
// wb_tgt_chk: passive protocol checker for a pipelined Wishbone target port
module wb_tgt_chk #(
  parameter int ADR_WIDTH  = 16,
  parameter int DAT_WIDTH  = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int TGA_WIDTH  = 1,
  parameter int TGWD_WIDTH = 1,
  parameter int MAX_PEND   = 4,
  parameter int TIMEOUT    = 64,
  parameter int PND_WIDTH  = $clog2(MAX_PEND + 2)
) (
  input  logic                  clk_i,
  input  logic                  async_rst_i,
  input  logic                  clr_i,
  input  logic                  tgt_cyc_o,
  input  logic                  tgt_stb_o,
  input  logic                  tgt_we_o,
  input  logic [SEL_WIDTH-1:0]  tgt_sel_o,
  input  logic [ADR_WIDTH-1:0]  tgt_adr_o,
  input  logic [DAT_WIDTH-1:0]  tgt_dat_o,
  input  logic [TGA_WIDTH-1:0]  tgt_tga_o,
  input  logic [TGWD_WIDTH-1:0] tgt_tgd_o,
  input  logic                  tgt_ack_i,
  input  logic                  tgt_err_i,
  input  logic                  tgt_rty_i,
  input  logic                  tgt_stall_i,
  output logic [PND_WIDTH-1:0]  pend_o,
  output logic                  busy_o,
  output logic [7:0]            err_o,
  output logic                  err_stb_o,
  output logic [15:0]           err_cnt_o
);
  typedef enum logic [1:0] {ST_RESET, ST_IDLE, ST_BUSY} state_t;
  localparam int TMO_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [PND_WIDTH-1:0] PEND_ONE = PND_WIDTH'(1);
  localparam logic [PND_WIDTH-1:0] PEND_MAX = PND_WIDTH'(MAX_PEND);
  localparam logic [PND_WIDTH-1:0] PEND_SAT = PND_WIDTH'(MAX_PEND + 1);
  localparam logic [TMO_WIDTH-1:0] TMO_ONE = TMO_WIDTH'(1);
  localparam logic [TMO_WIDTH-1:0] TMO_LIM = TMO_WIDTH'(TIMEOUT);
  localparam logic [TMO_WIDTH-1:0] TMO_PRE = TMO_WIDTH'(TIMEOUT - 1);
  state_t                state_q, state_d;
  logic [PND_WIDTH-1:0]  pend_q, pend_d;
  logic [TMO_WIDTH-1:0]  tmo_q, tmo_d;
  logic                  hold_q, we_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic [ADR_WIDTH-1:0]  adr_q;
  logic [DAT_WIDTH-1:0]  dat_q;
  logic [TGA_WIDTH-1:0]  tga_q;
  logic [TGWD_WIDTH-1:0] tgd_q;
  logic [7:0]            viol;
  logic                  req, term, field_chg;
  assign req    = tgt_cyc_o & tgt_stb_o & ~tgt_stall_i;
  assign term   = tgt_ack_i | tgt_err_i | tgt_rty_i;
  assign pend_o = pend_q;
  assign busy_o = state_q == ST_BUSY;
  // next state, outstanding-request count and stuck-cycle timer
  always_comb begin
    state_d = state_q != ST_RESET && tgt_cyc_o ? ST_BUSY : ST_IDLE;
    pend_d  = state_q == ST_RESET || !tgt_cyc_o ? '0
            : req && !term ? (pend_q == PEND_SAT ? pend_q : pend_q + PEND_ONE)
            : term && !req ? (pend_q == '0 ? pend_q : pend_q - PEND_ONE)
            : pend_q;
    tmo_d   = pend_q == '0 || term ? '0 : tmo_q == TMO_LIM ? tmo_q : tmo_q + TMO_ONE;
  end
  // violations observed this cycle; overflow is charged to the request that pushes past the limit
  always_comb begin
    field_chg = tgt_we_o != we_q || tgt_sel_o != sel_q || tgt_adr_o != adr_q || tgt_tga_o != tga_q ||
                (tgt_we_o && (tgt_dat_o != dat_q || tgt_tgd_o != tgd_q));
    viol[0] = state_q == ST_RESET && (tgt_cyc_o || tgt_stb_o);
    viol[1] = tgt_cyc_o && ((tgt_ack_i && tgt_err_i) || (tgt_ack_i && tgt_rty_i) || (tgt_err_i && tgt_rty_i));
    viol[2] = term && pend_q == '0;
    viol[3] = !tgt_cyc_o && pend_q != '0;
    viol[4] = tgt_stb_o && !tgt_cyc_o;
    viol[5] = hold_q && (!tgt_stb_o || field_chg);
    viol[6] = state_q != ST_RESET && req && !term && pend_q >= PEND_MAX;
    viol[7] = pend_q != '0 && !term && tmo_q == TMO_PRE;
  end
  // state, counters and the snapshot of the last request fields
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      state_q <= ST_RESET;
      pend_q  <= '0;
      tmo_q   <= '0;
      hold_q  <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      tga_q   <= '0;
      tgd_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
      hold_q  <= tgt_cyc_o & tgt_stb_o & tgt_stall_i;
      we_q    <= tgt_we_o;
      sel_q   <= tgt_sel_o;
      adr_q   <= tgt_adr_o;
      dat_q   <= tgt_dat_o;
      tga_q   <= tgt_tga_o;
      tgd_q   <= tgt_tgd_o;
    end
  end
  // sticky flags, violation strobe and saturating violation-cycle count
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      err_o     <= '0;
      err_stb_o <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      err_o     <= clr_i ? viol : err_o | viol;
      err_stb_o <= |viol;
      err_cnt_o <= clr_i ? {15'd0, |viol} : (|viol && err_cnt_o != 16'hFFFF) ? err_cnt_o + 16'd1 : err_cnt_o;
    end
  end
endmodule

// File: tb/tb_wb_tgt_chk.sv
// tb_wb_tgt_chk: randomized scoreboard bench for wb_tgt_chk against a behavioural model
module tb_wb_tgt_chk;
  localparam int MAX_PEND = 4;
  localparam int TIMEOUT  = 8;
  localparam int PW       = $clog2(MAX_PEND + 2);
  typedef struct {
    logic [PW-1:0] pend;
    logic          busy;
    logic [7:0]    err;
    logic          stb;
    logic [15:0]   cnt;
  } exp_t;
  logic          clk_i = 1'b0;
  logic          async_rst_i = 1'b1;
  logic          clr, cyc, stb, we, stall, ack, err, rty, tga, tgd;
  logic [1:0]    sel;
  logic [15:0]   adr, dat;
  logic [PW-1:0] pend_o;
  logic          busy_o, err_stb_o;
  logic [7:0]    err_o;
  logic [15:0]   err_cnt_o;
  exp_t          sbq[$];
  int            checks = 0, failures = 0;
  int            seq[6] = '{1, 2, 3, 2, 1, 0};
  bit            m_rst, m_hold, m_we, m_tga, m_tgd;
  int            m_pend, m_tmo, m_cnt;
  logic [7:0]    m_err;
  logic [1:0]    m_sel;
  logic [15:0]   m_adr, m_dat;

  wb_tgt_chk #(.MAX_PEND(MAX_PEND), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .async_rst_i(async_rst_i), .clr_i(clr),
    .tgt_cyc_o(cyc), .tgt_stb_o(stb), .tgt_we_o(we), .tgt_sel_o(sel),
    .tgt_adr_o(adr), .tgt_dat_o(dat), .tgt_tga_o(tga), .tgt_tgd_o(tgd),
    .tgt_ack_i(ack), .tgt_err_i(err), .tgt_rty_i(rty), .tgt_stall_i(stall),
    .pend_o(pend_o), .busy_o(busy_o), .err_o(err_o), .err_stb_o(err_stb_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bus(input logic c, input logic s, input logic st, input logic a);
    cyc = c; stb = s; stall = st; ack = a; err = 1'b0; rty = 1'b0; clr = 1'b0;
  endtask

  // Reference model: apply the checker rules to this cycle's inputs, queue the outputs due after the next edge.
  task automatic tick();
    exp_t e;
    logic [7:0] v;
    int req, term, raw, ntmo;
    req  = (cyc && stb && !stall) ? 1 : 0;
    term = (ack || err || rty) ? 1 : 0;
    raw  = m_pend + req - term;
    ntmo = (m_pend == 0 || term == 1) ? 0 : (m_tmo < TIMEOUT ? m_tmo + 1 : TIMEOUT);
    v = '0;
    v[0] = m_rst && (cyc || stb);
    v[1] = cyc && (int'(ack) + int'(err) + int'(rty) > 1);
    v[2] = term == 1 && m_pend == 0;
    v[3] = !cyc && m_pend > 0;
    v[4] = stb && !cyc;
    v[5] = m_hold && (!stb || we != m_we || sel != m_sel || adr != m_adr || tga != m_tga ||
                      (we && (dat != m_dat || tgd != m_tgd)));
    v[6] = !m_rst && cyc && raw > MAX_PEND && raw > m_pend;
    v[7] = ntmo == TIMEOUT && m_tmo != TIMEOUT;
    m_pend = (!m_rst && cyc) ? (raw < 0 ? 0 : raw > MAX_PEND + 1 ? MAX_PEND + 1 : raw) : 0;
    m_tmo  = ntmo;
    m_err  = clr ? v : (m_err | v);
    m_cnt  = clr ? (v != 0 ? 1 : 0) : (v != 0 && m_cnt < 65535 ? m_cnt + 1 : m_cnt);
    e.pend = PW'(m_pend);
    e.busy = !m_rst && cyc;
    e.err  = m_err;
    e.stb  = v != 0;
    e.cnt  = 16'(m_cnt);
    m_hold = cyc && stb && stall;
    m_we = we; m_sel = sel; m_adr = adr; m_dat = dat; m_tga = tga; m_tgd = tgd;
    m_rst  = 1'b0;
    sbq.push_back(e);
    @(negedge clk_i);
  endtask

  task automatic hard_reset(input logic keep_cyc);
    async_rst_i = 1'b1;
    bus(keep_cyc, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_pend", 16'(pend_o), 16'h0);
    chk("rst_busy", 16'(busy_o), 16'h0);
    chk("rst_err", 16'(err_o), 16'h0);
    chk("rst_stb", 16'(err_stb_o), 16'h0);
    chk("rst_cnt", err_cnt_o, 16'h0);
    m_rst = 1'b1; m_pend = 0; m_tmo = 0; m_hold = 1'b0; m_err = '0; m_cnt = 0;
    @(negedge clk_i);
    async_rst_i = 1'b0;
  endtask

  task automatic rnd_inputs();
    logic keep;
    int k;
    keep = m_hold && ($urandom_range(0, 9) != 0);
    cyc = cyc ? ($urandom_range(0, 99) >= 3) : ($urandom_range(0, 99) < 30);
    if (keep) begin
      cyc = 1'b1; stb = 1'b1;
    end else begin
      stb = cyc ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 2);
      we = 1'($urandom); sel = 2'($urandom); adr = 16'($urandom);
      dat = 16'($urandom); tga = 1'($urandom); tgd = 1'($urandom);
    end
    stall = $urandom_range(0, 99) < 30;
    ack = 1'b0; err = 1'b0; rty = 1'b0;
    if (cyc && m_pend > 0 && $urandom_range(0, 99) < 45) begin
      k = $urandom_range(0, 9);
      ack = k < 8; err = k == 8; rty = k == 9;
    end
    if ($urandom_range(0, 99) < 2) {ack, err, rty} = 3'($urandom);
    clr = $urandom_range(0, 99) < 3;
  endtask

  // Monitor: the DUT presents a fresh result every cycle; compare it with the oldest queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #2;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("sb_pend", 16'(pend_o), 16'(e.pend));
        chk("sb_busy", 16'(busy_o), 16'(e.busy));
        chk("sb_err", 16'(err_o), 16'(e.err));
        chk("sb_stb", 16'(err_stb_o), 16'(e.stb));
        chk("sb_cnt", err_cnt_o, e.cnt);
      end
    end
  end

  initial begin
    we = 1'b0; sel = 2'b11; adr = 16'h0100; dat = 16'hA5A5; tga = 1'b0; tgd = 1'b0;
    bus(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    hard_reset(1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      bus(1'b1, i < 3, 1'b0, i >= 3);
      tick();
      chk("t1_pend", 16'(pend_o), 16'(seq[i]));
    end
    chk("t1_busy", 16'(busy_o), 16'h1);
    chk("t1_err", 16'(err_o), 16'h0);
    bus(1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("t1_busy_end", 16'(busy_o), 16'h0);
    repeat (5) begin bus(1'b1, 1'b1, 1'b0, 1'b0); tick(); end
    chk("t2_err", 16'(err_o), 16'h0040);
    chk("t2_cnt", err_cnt_o, 16'h1);
    chk("t2_stb", 16'(err_stb_o), 16'h1);
    bus(1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("t2_stb_off", 16'(err_stb_o), 16'h0);
    chk("t2_cnt_hold", err_cnt_o, 16'h1);
    bus(1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("t2_abort", 16'(err_o), 16'h0048);
    bus(1'b0, 1'b0, 1'b0, 1'b0); clr = 1'b1; tick();
    chk("t2_clr_err", 16'(err_o), 16'h0);
    chk("t2_clr_cnt", err_cnt_o, 16'h0);
    bus(1'b1, 1'b0, 1'b0, 1'b1); tick();
    chk("t3_err", 16'(err_o), 16'h0004);
    bus(1'b0, 1'b0, 1'b0, 1'b0); clr = 1'b1; tick();
    chk("t3_clr_err", 16'(err_o), 16'h0);
    chk("t3_clr_cnt", err_cnt_o, 16'h0);
    for (int pass = 0; pass < 2; pass++) begin
      adr = 16'h1234; bus(1'b1, 1'b1, 1'b1, 1'b0); tick();
      if (pass == 0) adr = 16'h1235;
      bus(1'b1, 1'b1, 1'b1, 1'b0); tick();
      chk("t4_err", 16'(err_o), pass == 0 ? 16'h0020 : 16'h0000);
      bus(1'b1, 1'b1, 1'b0, 1'b0); tick();
      bus(1'b1, 1'b0, 1'b0, 1'b1); tick();
      bus(1'b0, 1'b0, 1'b0, 1'b0); tick();
      chk("t4_cnt", err_cnt_o, pass == 0 ? 16'h1 : 16'h0);
      bus(1'b0, 1'b0, 1'b0, 1'b0); clr = 1'b1; tick();
    end
    bus(1'b1, 1'b1, 1'b0, 1'b0); tick();
    for (int i = 1; i <= 11; i++) begin
      bus(1'b1, 1'b0, 1'b0, 1'b0); tick();
      chk("t5_err", 16'(err_o), i >= 8 ? 16'h0080 : 16'h0000);
    end
    chk("t5_cnt", err_cnt_o, 16'h1);
    bus(1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("t5_abort", 16'(err_o), 16'h0088);
    chk("t5_cnt2", err_cnt_o, 16'h2);
    bus(1'b0, 1'b0, 1'b0, 1'b0); clr = 1'b1; tick();
    hard_reset(1'b1);
    tick();
    bus(1'b1, 1'b0, 1'b0, 1'b1); rty = 1'b1; tick();
    chk("t6_err", 16'(err_o), 16'h0007);
    bus(1'b0, 1'b0, 1'b0, 1'b0); tick();
    repeat (2) begin bus(1'b1, 1'b1, 1'b0, 1'b0); tick(); end
    chk("t6_pend", 16'(pend_o), 16'h2);
    hard_reset(1'b0);
    tick();
    for (int n = 0; n < 3000; n++) begin
      rnd_inputs();
      tick();
    end
    bus(1'b0, 1'b0, 1'b0, 1'b0); tick();
    @(posedge clk_i);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
